lfsr_seg_capture: RTL and testbench
===================================

Name: lfsr_seg_capture

Overview:
- Downstream consumer of the 8-bit free-running LFSR.
- On a debounced push-button press, samples the LFSR value and shows it as two hex digits on two nvboard seven-segment displays.
- Also flags LFSR lock-up, i.e. a sampled value of 0, and counts captures.
- Sits between the LFSR output bus and the board segment/LED pins.

Parameters:
- DEB_CYCLES, 16, consecutive cycles the synchronised button must hold a level to be accepted; range 2..65535.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rnd_in  input  8  current LFSR value, synchronous to clk.
- btn  input  1  raw push button, active-high, asynchronous and bouncy.
- seg0  output  8  low hex digit, rnd sample[3:0]; active-low {a,b,c,d,e,f,g,dp}.
- seg1  output  8  high hex digit, rnd sample[7:4]; same encoding.
- cap_cnt  output  8  number of captures since reset, wraps modulo 256.
- lock_err  output  1  high while the displayed sample equals 8'h00.
- busy  output  1  high when the FSM is in any state other than IDLE.

Behaviour:
- Reset (async, active-high): sync flops=0, FSM=IDLE, debounce counter=0, sample=0, shown=0, seg0=seg1=8'hFF (blank), cap_cnt=0, lock_err=0, busy=0. Reset asserted mid-debounce aborts with no capture.
- Button synchronisation: btn passes through 2 flops to give btn_s. The FSM sees only btn_s.
- FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
- IDLE:
  - btn_s=1 -> PRESS_WAIT, cnt<=0.
- PRESS_WAIT:
  - btn_s=0 -> IDLE (bounce rejected).
  - Otherwise cnt<=cnt+1.
  - When cnt==DEB_CYCLES-1 with btn_s=1: go to HELD and raise the internal one-cycle capture strobe.
- HELD:
  - btn_s=0 -> REL_WAIT, cnt<=0.
  - Holding indefinitely produces no further capture.
- REL_WAIT:
  - btn_s=1 -> HELD (release bounce, no new capture).
  - Otherwise cnt++.
  - When cnt==DEB_CYCLES-1 with btn_s=0: go to IDLE.
- Capture cycle:
  - sample<=rnd_in as present in that cycle.
  - shown<=1.
  - cap_cnt<=cap_cnt+1, wrapping 8'hFF->8'h00.
- Display outputs:
  - seg0, seg1 and lock_err are registered from sample and shown, so they update 1 cycle after capture.
  - Total latency from btn_s rising: DEB_CYCLES+1 cycles. Add 2 cycles for the synchroniser.
- Hex encoding, active-low:
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71
  - dp is always off (bit0=1).
- Blanking: while shown=0, seg0=seg1=8'hFF.
- lock_err: shown && sample==8'h00. Cleared only by reset or a later non-zero capture.
- rnd_in changing every cycle is expected; only the capture-cycle value matters.

Optional Feature:
- Macro: LFSR_SEG_AUTO_EN.
- When defined:
  - Adds parameter AUTO_PERIOD (default 50_000_000) and input auto_en (1 bit).
  - While auto_en=1 and the FSM is in IDLE, a period counter raises the capture strobe every AUTO_PERIOD cycles.
  - A debounced button capture in the same cycle merges into a single capture (cap_cnt +1 only).
  - The period counter resets on any capture and whenever auto_en=0.
- When undefined: no auto_en port, no period counter. Behaviour is exactly as above.

Decomposition:
- Package lfsr_seg_pkg holds:
  - FSM state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT);
  - the 16-entry hex-to-segment constant table;
  - the blank constant 8'hFF.
- One sub-module, hex7seg: combinational 4-bit -> 8-bit active-low decoder, instantiated twice. Output registers stay in the parent.

Test Plan:
- Reset release with btn=0 for 100 cycles -> seg0=seg1=FF, cap_cnt=0, lock_err=0, busy=0.
- DEB_CYCLES=16, rnd_in=A5, btn high 40 cycles -> seg1=11, seg0=49, cap_cnt=1; updates exactly 19 cycles after the btn edge.
- btn pulses of 5 cycles high / 5 low, repeated 10 times -> cap_cnt stays 0, segments stay FF.
- btn held 1000 cycles, then released with 3-cycle bounce -> cap_cnt=1 only; FSM returns to IDLE; busy falls.
- Capture with rnd_in=00 -> seg0=seg1=03, lock_err=1; next capture with rnd_in=3C -> seg1=0D, seg0=63, lock_err=0.
- 256 clean presses -> cap_cnt wraps to 00. Separately, rst asserted at cycle 8 of PRESS_WAIT -> all outputs at reset values immediately, no capture.

Source files
------------

// File: rtl/lfsr_seg_pkg.sv
// lfsr_seg_pkg: shared types and constants for the LFSR capture/display slice.
//   state_e     - debounce FSM states
//   HEX_SEG     - hex digit to active-low {a,b,c,d,e,f,g,dp} segment pattern
//   SEG_BLANK   - all segments off
package lfsr_seg_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal point (bit 0) is kept high, so it is always dark.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

endpackage

// File: rtl/lfsr_seg_capture_hex7seg.sv
// hex7seg: combinational hex digit to seven-segment decoder.
//   hex - 4-bit digit value
//   seg - active-low {a,b,c,d,e,f,g,dp}, dp always off
module hex7seg
  import lfsr_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/lfsr_seg_capture.sv
// lfsr_seg_capture: samples the free-running LFSR on a debounced button press
// and shows the sample as two hex digits; flags a zero (lock-up) sample.
// Optional macro LFSR_SEG_AUTO_EN adds periodic auto-capture (auto_en port,
// AUTO_PERIOD parameter).
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   rnd_in   - current LFSR value
//   btn      - raw, bouncy push button (active-high)
//   seg0     - low hex digit, active-low segments (blank = 8'hFF)
//   seg1     - high hex digit, same encoding
//   cap_cnt  - captures since reset, wraps modulo 256
//   lock_err - displayed sample is 8'h00
//   busy     - debounce FSM is not idle
module lfsr_seg_capture
  import lfsr_seg_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
`ifdef LFSR_SEG_AUTO_EN
  ,
  parameter int AUTO_PERIOD = 50_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rnd_in,
  input  logic       btn,
`ifdef LFSR_SEG_AUTO_EN
  input  logic       auto_en,
`endif
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] cap_cnt,
  output logic       lock_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             btn_s;
  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             deb_cap_s;
  logic             cap_s;
  logic [7:0]       sample_r;
  logic             shown_r;
  logic [7:0]       cap_cnt_r;
  logic [7:0]       seg0_r;
  logic [7:0]       seg1_r;
  logic             lock_err_r;
  logic             busy_r;
  logic [7:0]       dig0_s;
  logic [7:0]       dig1_s;

  assign btn_s    = sync_r[1];
  assign seg0     = seg0_r;
  assign seg1     = seg1_r;
  assign cap_cnt  = cap_cnt_r;
  assign lock_err = lock_err_r;
  assign busy     = busy_r;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn};
    end
  end

  // Debounce FSM next-state, counter and capture strobe.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    deb_cap_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_s) begin
          state_next_s = PRESS_WAIT;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = HELD;
          cnt_next_s   = '0;
          deb_cap_s    = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next_s = REL_WAIT;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      REL_WAIT: begin
        if (btn_s) begin
          state_next_s = HELD;
          cnt_next_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // FSM state and debounce counter registers; busy mirrors the next state so
  // it is high exactly while the registered state is not IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

`ifdef LFSR_SEG_AUTO_EN
  logic [31:0] per_r;
  logic        auto_cap_s;

  // Periodic strobe while enabled and idle.
  always_comb begin
    auto_cap_s = auto_en && (state_r == IDLE) && (per_r == 32'(AUTO_PERIOD - 1));
    cap_s      = deb_cap_s | auto_cap_s;
  end

  // Period counter: restarts on any capture or when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_r <= 32'd0;
    end else if (!auto_en || cap_s) begin
      per_r <= 32'd0;
    end else if (state_r == IDLE) begin
      per_r <= per_r + 32'd1;
    end else begin
      per_r <= per_r;
    end
  end
`else
  // Only the debounced button can capture.
  always_comb begin
    cap_s = deb_cap_s;
  end
`endif

  // Capture register, visibility flag and capture counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r  <= 8'h00;
      shown_r   <= 1'b0;
      cap_cnt_r <= 8'h00;
    end else if (cap_s) begin
      sample_r  <= rnd_in;
      shown_r   <= 1'b1;
      cap_cnt_r <= cap_cnt_r + 8'd1;
    end else begin
      sample_r  <= sample_r;
      shown_r   <= shown_r;
      cap_cnt_r <= cap_cnt_r;
    end
  end

  hex7seg u_dig0 (.hex(sample_r[3:0]), .seg(dig0_s));
  hex7seg u_dig1 (.hex(sample_r[7:4]), .seg(dig1_s));

  // Registered display and lock-up flag, blank until the first capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg0_r     <= SEG_BLANK;
      seg1_r     <= SEG_BLANK;
      lock_err_r <= 1'b0;
    end else begin
      seg0_r     <= shown_r ? dig0_s : SEG_BLANK;
      seg1_r     <= shown_r ? dig1_s : SEG_BLANK;
      lock_err_r <= shown_r && (sample_r == 8'h00);
    end
  end

endmodule

// File: tb/tb_lfsr_seg_capture.sv
// tb_lfsr_seg_capture: directed self-checking bench for lfsr_seg_capture
// (DEB_CYCLES=16, default build).
module tb_lfsr_seg_capture;

  logic       clk;
  logic       rst;
  logic [7:0] rnd_in;
  logic       btn;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] cap_cnt;
  logic       lock_err;
  logic       busy;

  int tests;
  int fails;
  int n;

  lfsr_seg_capture #(.DEB_CYCLES(16), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rnd_in   (rnd_in),
    .btn      (btn),
`ifdef LFSR_SEG_AUTO_EN
    .auto_en  (1'b0),
`endif
    .seg0     (seg0),
    .seg1     (seg1),
    .cap_cnt  (cap_cnt),
    .lock_err (lock_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clean press: only the value present just before capture edge 19 is val;
  // every other cycle carries ~val so a mistimed capture is visible.
  task automatic press(input logic [7:0] val);
    btn = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      rnd_in = (k == 18) ? val : ~val;
    end
    btn = 1'b0;
    tick(22);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    btn    = 1'b0;
    rnd_in = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(100);

    // Idle after reset.
    check("rst_seg0", 16'(seg0), 16'h00FF);
    check("rst_seg1", 16'(seg1), 16'h00FF);
    check("rst_cnt", 16'(cap_cnt), 16'h0000);
    check("rst_lock", 16'(lock_err), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);

    // First press, A5, and latency from the first edge that samples btn.
    rnd_in = 8'hA5;
    btn    = 1'b1;
    tick(1);
    n = 0;
    while (seg0 == 8'hFF && n < 100) begin
      tick(1);
      n++;
    end
    check("latency", 16'(n), 16'd19);
    check("a5_seg1", 16'(seg1), 16'h0011);
    check("a5_seg0", 16'(seg0), 16'h0049);
    check("a5_cnt", 16'(cap_cnt), 16'h0001);
    check("a5_busy_held", 16'(busy), 16'h0001);
    tick(20);
    btn = 1'b0;
    tick(25);
    check("a5_busy_rel", 16'(busy), 16'h0000);
    check("a5_cnt_after", 16'(cap_cnt), 16'h0001);

    // Bouncy 5/5 pulses after a fresh reset: never accepted.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    for (int p = 0; p < 10; p++) begin
      btn = 1'b1;
      tick(5);
      btn = 1'b0;
      tick(5);
    end
    tick(30);
    check("bounce_cnt", 16'(cap_cnt), 16'h0000);
    check("bounce_seg0", 16'(seg0), 16'h00FF);
    check("bounce_seg1", 16'(seg1), 16'h00FF);

    // Long hold with bouncy release: exactly one capture.
    rnd_in = 8'h7E;
    btn    = 1'b1;
    tick(1000);
    for (int b = 0; b < 3; b++) begin
      btn = 1'b0;
      tick(1);
      btn = 1'b1;
      tick(1);
    end
    btn = 1'b0;
    tick(5);
    check("hold_busy_rel", 16'(busy), 16'h0001);
    tick(30);
    check("hold_cnt", 16'(cap_cnt), 16'h0001);
    check("hold_busy", 16'(busy), 16'h0000);
    check("hold_seg1", 16'(seg1), 16'h001F);
    check("hold_seg0", 16'(seg0), 16'h0061);

    // Lock-up sample, then a non-zero sample clears it.
    press(8'h00);
    check("zero_seg0", 16'(seg0), 16'h0003);
    check("zero_seg1", 16'(seg1), 16'h0003);
    check("zero_lock", 16'(lock_err), 16'h0001);
    check("zero_cnt", 16'(cap_cnt), 16'h0002);
    press(8'h3C);
    check("3c_seg1", 16'(seg1), 16'h000D);
    check("3c_seg0", 16'(seg0), 16'h0063);
    check("3c_lock", 16'(lock_err), 16'h0000);
    rnd_in = 8'h00;
    tick(10);
    check("3c_lock_nocap", 16'(lock_err), 16'h0000);

    // 256 presses from reset: counter wraps back to zero.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 255; i++) begin
      press(8'(i + 1));
    end
    check("wrap_ff", 16'(cap_cnt), 16'h00FF);
    check("wrap_seg1", 16'(seg1), 16'h0071);
    check("wrap_seg0", 16'(seg0), 16'h0071);
    press(8'h12);
    check("wrap_00", 16'(cap_cnt), 16'h0000);
    check("wrap_seg_12", {seg1, seg0}, 16'h9F25);

    // Reset at cycle 8 of PRESS_WAIT aborts the press.
    btn = 1'b1;
    tick(11);
    check("abort_busy", 16'(busy), 16'h0001);
    rst = 1'b1;
    #1;
    check("abort_seg0", 16'(seg0), 16'h00FF);
    check("abort_seg1", 16'(seg1), 16'h00FF);
    check("abort_cnt", 16'(cap_cnt), 16'h0000);
    check("abort_lock", 16'(lock_err), 16'h0000);
    check("abort_busy0", 16'(busy), 16'h0000);
    btn = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(40);
    check("abort_nocap", 16'(cap_cnt), 16'h0000);
    check("abort_blank", {seg1, seg0}, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
